// File: rtl/window_line_buffer.sv
// window_line_buffer: turns a raster-order 8-bit pixel stream into SIZE x SIZE neighbourhoods.
// SIZE-1 previous image lines are kept in line buffers. Each valid window is presented with a
// one-cycle start pulse. The stream then stalls until the downstream convolution reports done.
module window_line_buffer #(
    parameter int unsigned SIZE  = 3,
    parameter int unsigned IMG_W = 64,
    parameter int unsigned IMG_H = 64
) (
    input  logic                                   clk,
    input  logic                                   n_rst,
    input  logic [7:0]                             pixel_in,
    input  logic                                   pixel_valid,
    output logic                                   pixel_ready,
    output logic [SIZE-1:0][SIZE-1:0][7:0]         window,
    output logic                                   start,
    input  logic                                   compute_done,
    output logic [$clog2(IMG_W)-1:0]               win_x,
    output logic [$clog2(IMG_H)-1:0]               win_y,
    output logic                                   frame_done
);

    localparam int unsigned XW = $clog2(IMG_W);
    localparam int unsigned YW = $clog2(IMG_H);

    // Reject parameter sets the window geometry cannot support.
    if (SIZE < 2 || SIZE > 15 || SIZE > IMG_W || SIZE > IMG_H) begin : g_bad_params
        $error("window_line_buffer: SIZE must be 2..15 and fit inside the image");
    end

    typedef enum logic {
        StStream,
        StWaitDone
    } state_e;

    state_e                         state_q;
    logic [XW-1:0]                  col_q;
    logic [YW-1:0]                  row_q;
    logic                           start_q;
    logic                           frame_done_q;
    logic [XW-1:0]                  win_x_q;
    logic [YW-1:0]                  win_y_q;
    // Set when the pending window was produced by the last pixel of the frame.
    logic                           last_q;

    logic [SIZE-1:0][SIZE-1:0][7:0] window_d;
    logic [SIZE-1:0][SIZE-1:0][7:0] window_q;

    // lb_q[0] is the previous line, lb_q[SIZE-2] the oldest line. Contents are never reset.
    logic [7:0]                     lb_q [SIZE-1][IMG_W];

    logic                           accept;
    logic                           col_last;
    logic                           row_last;
    logic                           win_ok;

    // Ready only while streaming and never during the reset cycle.
    assign pixel_ready = (state_q == StStream) && !n_rst;
    assign accept      = pixel_valid && pixel_ready;

    // Position decode of the pixel being offered, compared at 32-bit unsigned width.
    assign col_last = (32'(col_q) == IMG_W - 1);
    assign row_last = (32'(row_q) == IMG_H - 1);
    assign win_ok   = (32'(row_q) >= SIZE - 1) && (32'(col_q) >= SIZE - 1);

    // Line buffers: push the accepted pixel into lb[0] and age each stored line by one slot.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb_q[0][col_q] <= pixel_in;
            for (int k = 1; k < int'(SIZE) - 1; k++) begin
                lb_q[k][col_q] <= lb_q[k-1][col_q];
            end
        end
    end

    // Window next state: shift columns left and load the new rightmost column on accept.
    always_comb begin
        window_d = window_q;
        if (accept) begin
            for (int r = 0; r < int'(SIZE); r++) begin
                for (int c = 0; c < int'(SIZE) - 1; c++) begin
                    window_d[r][c] = window_q[r][c+1];
                end
            end
            // Top of the new column is the oldest stored line, bottom is the live pixel.
            for (int r = 0; r < int'(SIZE) - 1; r++) begin
                window_d[r][SIZE-1] = lb_q[int'(SIZE) - 2 - r][col_q];
            end
            window_d[SIZE-1][SIZE-1] = pixel_in;
        end
    end

    // Window register; no accepts happen in WAIT_DONE so it holds there on its own.
    always_ff @(posedge clk) begin
        if (n_rst) begin
            window_q <= '0;
        end else begin
            window_q <= window_d;
        end
    end

    // Control FSM with raster counters and registered start/frame_done/position outputs.
    always_ff @(posedge clk) begin
        if (n_rst) begin
            state_q      <= StStream;
            col_q        <= '0;
            row_q        <= '0;
            start_q      <= 1'b0;
            frame_done_q <= 1'b0;
            win_x_q      <= '0;
            win_y_q      <= '0;
            last_q       <= 1'b0;
        end else begin
            start_q      <= 1'b0;
            frame_done_q <= 1'b0;
            unique case (state_q)
                StStream: begin
                    if (accept) begin
                        if (col_last) begin
                            col_q <= '0;
                            row_q <= row_last ? '0 : row_q + YW'(1);
                        end else begin
                            col_q <= col_q + XW'(1);
                        end
                        if (win_ok) begin
                            start_q <= 1'b1;
                            win_x_q <= col_q - XW'(SIZE - 1);
                            win_y_q <= row_q - YW'(SIZE - 1);
                            last_q  <= col_last && row_last;
                            state_q <= StWaitDone;
                        end
                    end
                end
                StWaitDone: begin
                    if (compute_done) begin
                        frame_done_q <= last_q;
                        last_q       <= 1'b0;
                        state_q      <= StStream;
                    end
                end
                default: begin
                    state_q <= StStream;
                end
            endcase
        end
    end

    assign window     = window_q;
    assign start      = start_q;
    assign frame_done = frame_done_q;
    assign win_x      = win_x_q;
    assign win_y      = win_y_q;

endmodule

// File: tb/tb_window_line_buffer.sv
// Bench for window_line_buffer with SIZE=3 on a 4x4 image; pixel value = {row, col}.
module tb_window_line_buffer;

    localparam int unsigned SIZE  = 3;
    localparam int unsigned IMG_W = 4;
    localparam int unsigned IMG_H = 4;

    typedef logic [SIZE-1:0][SIZE-1:0][7:0] win_t;

    typedef struct {
        logic       valid;
        logic [7:0] pix;
        logic       done;
        logic       exp_start;
        logic       exp_fd;
        logic       exp_ready;
    } vec_t;

    typedef struct {
        win_t       win;
        logic [1:0] x;
        logic [1:0] y;
    } exp_t;

    logic       clk;
    logic       n_rst;
    logic [7:0] pixel_in;
    logic       pixel_valid;
    logic       pixel_ready;
    win_t       window;
    logic       start;
    logic       compute_done;
    logic [1:0] win_x;
    logic [1:0] win_y;
    logic       frame_done;

    window_line_buffer #(
        .SIZE (SIZE),
        .IMG_W(IMG_W),
        .IMG_H(IMG_H)
    ) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .pixel_in    (pixel_in),
        .pixel_valid (pixel_valid),
        .pixel_ready (pixel_ready),
        .window      (window),
        .start       (start),
        .compute_done(compute_done),
        .win_x       (win_x),
        .win_y       (win_y),
        .frame_done  (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_pass   = 0;
    vec_t vecs[$];
    exp_t sb[$];
    exp_t held;
    logic prev_ready;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Reference window whose bottom-right pixel is pix: entry [r][c] = pixel (y+r, x+c).
    function automatic exp_t make_exp(input logic [7:0] pix);
        exp_t e;
        int   x;
        int   y;
        x = int'(pix[3:0]) - (int'(SIZE) - 1);
        y = int'(pix[7:4]) - (int'(SIZE) - 1);
        for (int r = 0; r < int'(SIZE); r++) begin
            for (int c = 0; c < int'(SIZE); c++) begin
                e.win[r][c] = {4'(y + r), 4'(x + c)};
            end
        end
        e.x = 2'(x);
        e.y = 2'(y);
        return e;
    endfunction

    function automatic vec_t mk(input logic v, input logic [7:0] p, input logic d,
                                input logic es, input logic efd, input logic er);
        vec_t t;
        t = '{valid: v, pix: p, done: d, exp_start: es, exp_fd: efd, exp_ready: er};
        return t;
    endfunction

    function automatic logic [7:0] pix_of(input int idx);
        return {4'(idx / int'(IMG_W)), 4'(idx % int'(IMG_W))};
    endfunction

    // Raster run of pixels that must be accepted without raising start.
    task automatic add_run(input int from_idx, input int to_idx);
        for (int i = from_idx; i <= to_idx; i++) vecs.push_back(mk(1, pix_of(i), 0, 0, 0, 1));
    endtask

    // Apply one cycle of stimulus and compare the outputs #1 after the clock edge.
    task automatic step(input vec_t v);
        pixel_valid  = v.valid;
        pixel_in     = v.pix;
        compute_done = v.done;
        if (v.valid && prev_ready && v.pix[7:4] >= 4'(SIZE - 1) && v.pix[3:0] >= 4'(SIZE - 1))
            sb.push_back(make_exp(v.pix));
        @(posedge clk);
        #1;
        check($sformatf("start@%02h", v.pix), 128'(start), 128'(v.exp_start));
        check($sformatf("frame_done@%02h", v.pix), 128'(frame_done), 128'(v.exp_fd));
        check($sformatf("pixel_ready@%02h", v.pix), 128'(pixel_ready), 128'(v.exp_ready));
        if (start) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL scoreboard: start at pixel %02h with no window expected", v.pix);
            end else begin
                held = sb.pop_front();
                check($sformatf("window@%02h", v.pix), 128'(window), 128'(held.win));
                check($sformatf("win_x@%02h", v.pix), 128'(win_x), 128'(held.x));
                check($sformatf("win_y@%02h", v.pix), 128'(win_y), 128'(held.y));
            end
        end else if (!v.exp_ready) begin
            check($sformatf("window_hold@%02h", v.pix), 128'(window), 128'(held.win));
        end
        pixel_valid  = 1'b0;
        compute_done = 1'b0;
        prev_ready   = v.exp_ready;
    endtask

    initial begin
        n_rst        = 1'b1;
        pixel_valid  = 1'b0;
        pixel_in     = '0;
        compute_done = 1'b0;
        prev_ready   = 1'b0;

        // Stimulus table: first window, backpressure, row wrap with gaps, frame end, next frame.
        add_run(0, 9);
        vecs.push_back(mk(1, 8'h22, 0, 1, 0, 0));
        repeat (5) vecs.push_back(mk(1, 8'h23, 0, 0, 0, 0));
        vecs.push_back(mk(1, 8'h23, 1, 0, 0, 1));
        vecs.push_back(mk(1, 8'h23, 0, 1, 0, 0));
        vecs.push_back(mk(0, 8'h00, 1, 0, 0, 1));
        vecs.push_back(mk(0, 8'h00, 0, 0, 0, 1));
        vecs.push_back(mk(1, 8'h30, 1, 0, 0, 1));  // compute_done while streaming is ignored
        vecs.push_back(mk(0, 8'h00, 0, 0, 0, 1));
        vecs.push_back(mk(1, 8'h31, 0, 0, 0, 1));
        vecs.push_back(mk(0, 8'h00, 0, 0, 0, 1));
        vecs.push_back(mk(1, 8'h32, 0, 1, 0, 0));
        vecs.push_back(mk(0, 8'h00, 1, 0, 0, 1));
        vecs.push_back(mk(1, 8'h33, 0, 1, 0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0));
        vecs.push_back(mk(0, 8'h00, 1, 0, 1, 1));
        vecs.push_back(mk(0, 8'h00, 0, 0, 0, 1));
        add_run(0, 9);
        vecs.push_back(mk(1, 8'h22, 0, 1, 0, 0));
        vecs.push_back(mk(0, 8'h00, 1, 0, 0, 1));

        // Reset held for two cycles.
        repeat (2) begin
            @(posedge clk);
            #1;
            check("rst_start", 128'(start), 128'(0));
            check("rst_frame_done", 128'(frame_done), 128'(0));
            check("rst_window", 128'(window), 128'(0));
            check("rst_pixel_ready", 128'(pixel_ready), 128'(0));
        end
        n_rst = 1'b0;
        #1;
        check("release_pixel_ready", 128'(pixel_ready), 128'(1));
        check("release_win_xy", 128'({win_x, win_y}), 128'(0));
        prev_ready = 1'b1;

        for (int i = 0; i < vecs.size(); i++) step(vecs[i]);

        // Finish the second frame and reset while waiting on its last window, with compute_done.
        step(mk(1, 8'h23, 0, 1, 0, 0));
        step(mk(0, 8'h00, 1, 0, 0, 1));
        step(mk(1, 8'h30, 0, 0, 0, 1));
        step(mk(1, 8'h31, 0, 0, 0, 1));
        step(mk(1, 8'h32, 0, 1, 0, 0));
        step(mk(0, 8'h00, 1, 0, 0, 1));
        step(mk(1, 8'h33, 0, 1, 0, 0));
        step(mk(0, 8'h00, 0, 0, 0, 0));
        n_rst        = 1'b1;
        compute_done = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_start", 128'(start), 128'(0));
        check("midrst_frame_done", 128'(frame_done), 128'(0));
        check("midrst_pixel_ready", 128'(pixel_ready), 128'(0));
        check("midrst_window", 128'(window), 128'(0));
        n_rst        = 1'b0;
        compute_done = 1'b0;
        #1;
        check("midrst_release_ready", 128'(pixel_ready), 128'(1));
        prev_ready = 1'b1;

        // Counters restart at (0,0): the first window appears again at pixel 0x22.
        for (int i = 0; i <= 9; i++) step(mk(1, pix_of(i), 0, 0, 0, 1));
        step(mk(1, 8'h22, 0, 1, 0, 0));
        step(mk(0, 8'h00, 1, 0, 0, 1));
        step(mk(0, 8'h00, 0, 0, 0, 1));

        check("scoreboard_drained", 128'(sb.size()), 128'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
